// File: rtl/dual_port_sync_ram.sv
// Simple-dual-port synchronous RAM: one byte-enabled write port, one read port with
// 1- or 2-cycle latency, configurable read-during-write, and an optional post-reset clear sweep.
module dual_port_sync_ram #(
    parameter int    ADDR_WIDTH    = 4,
    parameter int    DATA_WIDTH    = 32,
    parameter int    DEPTH         = 16,
    parameter int    READ_LATENCY  = 1,
    parameter string RDW_MODE      = "WRITE_FIRST",
    parameter bit    INIT_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_address,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_byte_enable,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_address,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_busy
);

    localparam int NumBytes = DATA_WIDTH / 8;
    localparam bit WriteFirst = (RDW_MODE == "WRITE_FIRST");
    localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    ready;
    logic                    wr_in_range, rd_in_range;
    logic                    wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0]   wr_old, wr_merged, rd_word;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    src_valid;
    logic [DATA_WIDTH-1:0]   src_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT_ON_RESET ? StClear : StReady;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            StClear: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LastAddr) begin
                    state_d   = StReady;
                    clr_ptr_d = '0;
                end
            end
            StReady: state_d = StReady;
            default: state_d = StReady;
        endcase
    end

    assign ready     = (state_q == StReady);
    assign init_busy = (state_q == StClear);

    // Extended compare stays correct when DEPTH is not a power of two.
    assign wr_in_range = ({1'b0, wr_address} < DepthExt);
    assign rd_in_range = ({1'b0, rd_address} < DepthExt);
    assign wr_accept   = ready && wr_en && wr_in_range;
    assign rd_accept   = ready && rd_en;

    assign wr_old = mem[wr_address];

    always_comb begin
        wr_merged = wr_old;
        for (int b = 0; b < NumBytes; b++) begin
            if (wr_byte_enable[b]) begin
                wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (WriteFirst && wr_accept && (wr_address == rd_address)) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem[rd_address];
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_address;
        mem_wdata = wr_merged;
        if (!reset) begin
            if (state_q == StClear) begin
                mem_we    = 1'b1;
                mem_addr  = clr_ptr_q;
                mem_wdata = '0;
            end else begin
                mem_we = wr_accept;
            end
        end
    end

    // Storage carries no reset; only the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  pipe_valid_q;
        logic [DATA_WIDTH-1:0] pipe_data_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                pipe_valid_q <= 1'b0;
                pipe_data_q  <= '0;
            end else begin
                pipe_valid_q <= rd_accept;
                if (rd_accept) begin
                    pipe_data_q <= rd_word;
                end
            end
        end

        assign src_valid = pipe_valid_q;
        assign src_data  = pipe_data_q;
    end else begin : g_lat1
        assign src_valid = rd_accept;
        assign src_data  = rd_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= src_valid;
            if (src_valid) begin
                rd_data <= src_data;
            end
        end
    end

endmodule

// File: doc/dual_port_sync_ram.md
# dual_port_sync_ram

Parametrised simple-dual-port synchronous RAM with one write port and one read port, sharing a single clock. Writes support per-byte enables. Reads have configurable latency and a valid strobe. Read-during-write behaviour on the same address is configurable. An optional clear sequence runs after reset and zeroes the whole array. The block replaces the single-port, tri-state-bus RAM wherever a producer and a consumer must access storage in the same cycle, such as register files and sample buffers.

## Interface
Parameters:
- ADDR_WIDTH, 4, address bits; must satisfy 2^ADDR_WIDTH >= DEPTH
- DATA_WIDTH, 32, word width; must be a multiple of 8
- DEPTH, 16, number of words
- READ_LATENCY, 1, cycles from accepted read to valid data; legal values are 1 or 2
- RDW_MODE, "WRITE_FIRST", same-address read-during-write result; "WRITE_FIRST" or "READ_FIRST"
- INIT_ON_RESET, 1, when 1 the array is zeroed after reset

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write request
- wr_address  input  ADDR_WIDTH  write word address
- wr_data  input  DATA_WIDTH  write data
- wr_byte_enable  input  DATA_WIDTH/8  bit b enables byte b, i.e. bits [8b+7:8b]
- rd_en  input  1  read request
- rd_address  input  ADDR_WIDTH  read word address
- rd_data  output  DATA_WIDTH  read data
- rd_valid  output  1  single-cycle strobe marking new rd_data
- init_busy  output  1  clear sequence in progress; requests are ignored while high

## Operation
- State machine with states CLEAR and READY.
- Reset behaviour:
  - With INIT_ON_RESET=1, reset forces state CLEAR and clear pointer 0.
  - With INIT_ON_RESET=0, reset forces state READY.
- CLEAR state:
  - Each cycle, writes 0 to mem[pointer] and increments the pointer.
  - After writing address DEPTH-1, moves to READY.
  - The sweep takes exactly DEPTH cycles.
- In CLEAR, wr_en and rd_en are ignored. No write occurs and no rd_valid is produced.
- Writes (READY only):
  - A write occurs when wr_en=1 at an edge.
  - Only bytes with wr_byte_enable[b]=1 are updated; the other bytes keep their old value.
  - wr_byte_enable=0 leaves the word unchanged.
  - wr_address >= DEPTH: the write is dropped silently.
- Reads (READY only):
  - A read is accepted when rd_en=1 at an edge.
  - rd_data is the word at rd_address, sampled as defined below.
  - rd_address >= DEPTH returns 0.
- Read-during-write, same address in the same cycle:
  - WRITE_FIRST: returns the merged word. Enabled bytes carry new data; disabled bytes carry old data.
  - READ_FIRST: returns the pre-write word.
- Different addresses: the read and the write are fully independent.
- rd_data holds its last value when no read completes. It never goes X or Z after reset.
- Back-to-back reads are allowed every cycle. Throughput is 1 read and 1 write per cycle.

## Timing
- Reset values:
  - rd_data = 0
  - rd_valid = 0
  - READ_LATENCY=2 pipeline stage cleared to 0 with its valid bit at 0
  - init_busy = 1 if INIT_ON_RESET=1, else 0
- Clear timing:
  - init_busy stays high through reset and DEPTH further cycles.
  - It falls on the edge after the last clear write.
  - Reads or writes are first accepted on the edge at which init_busy is sampled 0.
- Read accepted at edge N:
  - rd_valid=1 and rd_data updated in the cycle following edge N+READ_LATENCY-1.
  - For READ_LATENCY=1, that is directly after edge N.
  - rd_valid is high for exactly one cycle per accepted read.
- A write at edge N is visible to a read accepted at edge N+1 in either RDW_MODE.
- Reset asserted mid-operation:
  - In-flight reads are discarded, with no rd_valid.
  - The clear sequence restarts at address 0.
  - Reset mid-clear also restarts the sweep at 0.
- Memory contents are not reset when INIT_ON_RESET=0.

## Test plan
- Clear sweep:
  - Stimulus: DEPTH=16, INIT_ON_RESET=1. Reset for 2 cycles, then read all 16 addresses once init_busy falls.
  - Required response: init_busy high for exactly 16 cycles after reset release, and all reads return 0.
- Byte-enable merge:
  - Stimulus: write 0xAABBCCDD to address 3 with byte enable 0xF, then write 0x11223344 with byte enable 0x5, then read address 3.
  - Required response: 0xAA22CC44 with rd_valid one cycle later at READ_LATENCY=1, or two cycles later at READ_LATENCY=2.
- Collision:
  - Stimulus: address 5 holds 0x00000000; same-cycle write of 0xDEADBEEF with byte enable 0xF and read of address 5.
  - Required response: rd_data 0xDEADBEEF in WRITE_FIRST, 0x00000000 in READ_FIRST.
- Streaming:
  - Stimulus: write addresses 0–15 with value 0x100+i, then issue 16 consecutive reads, one per cycle.
  - Required response: 16 consecutive rd_valid pulses, in order, with data 0x100..0x10F and no gaps.
- Ignored and out-of-range requests:
  - Stimulus: wr_en and rd_en asserted during CLEAR; wr_address=15 with DEPTH=12.
  - Required response: no memory change and no rd_valid during CLEAR. A read of address 15 returns 0 with rd_valid=1.
- Reset mid-read:
  - Stimulus: READ_LATENCY=2, read accepted, then reset asserted on the next edge.
  - Required response: no rd_valid, rd_data=0, and the clear sweep restarts from 0.
